// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter with a per-tenure hold limit.
// The winner is registered as a binary index plus a one-hot grant that
// drives the shared datapath select. A tenure ends when the owner drops its
// request or, if MAX_HOLD is non-zero, after MAX_HOLD consecutive cycles.
// On release the priority pointer moves past the old owner and a new winner
// is chosen on the same edge, so back-to-back tenures have no idle bubble.
//
// Handshake: there is no ready/valid pair here. A requester raises req[i]
// and keeps it high while it wants the resource; it owns the resource in
// every cycle where gnt[i]=1. gnt_vld is simply |gnt. Dropping req[i]
// ends the tenure at the next edge. A request arriving while another
// requester owns the grant waits; it never preempts.
module rr_arb4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_vld,
    output logic       timeout,
    output logic       dbg_state
);

    localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [1:0]    r_ptr;
    logic [1:0]    w_ptr_nxt;
    logic [1:0]    r_idx;
    logic [1:0]    w_idx_nxt;
    logic [3:0]    r_gnt;
    logic [3:0]    w_gnt_nxt;
    logic [HW-1:0] r_hold;
    logic [HW-1:0] w_hold_nxt;
    logic          r_timeout;
    logic          w_timeout_nxt;

    logic          w_hold_hit;
    logic          w_release;
    logic [1:0]    w_sptr;
    logic [3:0]    w_rot;
    logic          w_found;
    logic [1:0]    w_off;
    logic [1:0]    w_win;

    // Release condition and the round-robin winner search. On a release
    // the search starts just after the outgoing owner, so that owner can
    // only win again when nobody else is requesting.
    always_comb begin
        w_hold_hit = (MAX_HOLD != 0) && (r_hold == HOLD_MAX);
        w_release  = (r_state == S_GRANT) && (!req[r_idx] || w_hold_hit);
        w_sptr     = w_release ? (r_idx + 2'd1) : r_ptr;
        for (int k = 0; k < 4; k++) begin
            w_rot[k] = req[2'(w_sptr + 2'(k))];
        end
        w_found = |w_rot;
        if (w_rot[0])      w_off = 2'd0;
        else if (w_rot[1]) w_off = 2'd1;
        else if (w_rot[2]) w_off = 2'd2;
        else               w_off = 2'd3;
        w_win = w_sptr + w_off;
    end

    // Next-state and next-output logic for the IDLE/GRANT controller.
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_idx_nxt     = r_idx;
        w_gnt_nxt     = r_gnt;
        w_hold_nxt    = r_hold;
        w_timeout_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_GRANT;
                    w_idx_nxt   = w_win;
                    w_gnt_nxt   = 4'b0001 << w_win;
                    w_hold_nxt  = HOLD_ONE;
                end
            end
            S_GRANT: begin
                if (w_release) begin
                    w_ptr_nxt     = w_sptr;
                    // Only a forced release with the request still up is a timeout.
                    w_timeout_nxt = w_hold_hit && req[r_idx];
                    if (w_found) begin
                        w_idx_nxt  = w_win;
                        w_gnt_nxt  = 4'b0001 << w_win;
                        w_hold_nxt = HOLD_ONE;
                    end else begin
                        // Index keeps its last value while idle.
                        w_state_nxt = S_IDLE;
                        w_gnt_nxt   = 4'b0000;
                    end
                end else if (MAX_HOLD != 0) begin
                    w_hold_nxt = r_hold + HOLD_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = 4'b0000;
            end
        endcase
    end

    // State and output registers; reset drops any grant immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= 2'd0;
            r_idx     <= 2'd0;
            r_gnt     <= 4'b0000;
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_idx     <= w_idx_nxt;
            r_gnt     <= w_gnt_nxt;
            r_hold    <= w_hold_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_idx;
    assign gnt_vld   = |r_gnt;
    assign timeout   = r_timeout;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_rr_arb4.sv
// Bench for rr_arb4. Three instances (MAX_HOLD = 8, 2, 0) share clock, reset
// and request inputs. A behavioural model tracks owner, pointer and tenure
// length per instance with plain integers; the driver pushes the expected
// post-edge outputs into a queue and a negedge monitor pops and compares.
module tb_rr_arb4;

    localparam int NI = 3;
    localparam int EW = 9;  // {state, timeout, vld, idx[1:0], gnt[3:0]}

    logic       clk;
    logic       rst;
    logic [3:0] req;

    logic [3:0] gnt_a   [NI];
    logic [1:0] idx_a   [NI];
    logic       vld_a   [NI];
    logic       to_a    [NI];
    logic       st_a    [NI];

    int mh [NI] = '{8, 2, 0};

    // model state per instance
    int m_owner [NI];
    int m_ptr   [NI];
    int m_ten   [NI];
    int m_last  [NI];
    int m_to    [NI];

    logic [NI*EW-1:0] exp_q [$];

    int n_tests = 0;
    int n_fail  = 0;

    rr_arb4 #(.MAX_HOLD(8)) u_h8 (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt_a[0]), .gnt_idx(idx_a[0]),
        .gnt_vld(vld_a[0]), .timeout(to_a[0]), .dbg_state(st_a[0]));
    rr_arb4 #(.MAX_HOLD(2)) u_h2 (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt_a[1]), .gnt_idx(idx_a[1]),
        .gnt_vld(vld_a[1]), .timeout(to_a[1]), .dbg_state(st_a[1]));
    rr_arb4 #(.MAX_HOLD(0)) u_h0 (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt_a[2]), .gnt_idx(idx_a[2]),
        .gnt_vld(vld_a[2]), .timeout(to_a[2]), .dbg_state(st_a[2]));

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // first requester at or after position p in circular order, -1 if none
    function automatic int search(input int p, input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_step(input logic rst_v, input logic [3:0] r);
        for (int i = 0; i < NI; i++) begin
            if (rst_v) begin
                m_owner[i] = -1; m_ptr[i] = 0; m_ten[i] = 0; m_last[i] = 0; m_to[i] = 0;
            end else if (m_owner[i] < 0) begin
                m_to[i] = 0;
                m_owner[i] = search(m_ptr[i], r);
                if (m_owner[i] >= 0) begin
                    m_ten[i] = 1; m_last[i] = m_owner[i];
                end
            end else begin
                bit still = r[m_owner[i]];
                bit limit = (mh[i] != 0) && (m_ten[i] == mh[i]);
                if (still && !limit) begin
                    m_ten[i] = m_ten[i] + 1;
                    m_to[i] = 0;
                end else begin
                    m_to[i] = (still && limit) ? 1 : 0;
                    m_ptr[i] = (m_owner[i] + 1) % 4;
                    m_owner[i] = search(m_ptr[i], r);
                    if (m_owner[i] >= 0) begin
                        m_ten[i] = 1; m_last[i] = m_owner[i];
                    end
                end
            end
        end
    endtask

    function automatic logic [EW-1:0] model_out(input int i);
        logic [3:0] g;
        g = (m_owner[i] >= 0) ? (4'b0001 << m_owner[i]) : 4'b0000;
        return {(m_owner[i] >= 0), m_to[i][0], (m_owner[i] >= 0), 2'(m_last[i]), g};
    endfunction

    // driver: apply inputs, advance model, push expectation after the edge
    task automatic drive(input logic rst_v, input logic [3:0] r);
        logic [NI*EW-1:0] e;
        rst = rst_v;
        req = r;
        model_step(rst_v, r);
        for (int i = 0; i < NI; i++) e[i*EW +: EW] = model_out(i);
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    // monitor: every cycle the outputs are present; compare against queue
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                logic [NI*EW-1:0] e;
                e = exp_q.pop_front();
                for (int i = 0; i < NI; i++) begin
                    logic [EW-1:0] act;
                    act = {st_a[i], to_a[i], vld_a[i], idx_a[i], gnt_a[i]};
                    n_tests++;
                    if (act !== e[i*EW +: EW]) begin
                        n_fail++;
                        $display("FAIL outputs inst=%0d (MAX_HOLD=%0d) t=%0t got st/to/vld/idx/gnt=%b required %b",
                                 i, mh[i], $time, act, e[i*EW +: EW]);
                    end
                end
            end
        end
    end

    logic [3:0] rot_exp [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                                4'b0100, 4'b1000, 4'b1000, 4'b0001};
    logic [3:0] rq;

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        for (int i = 0; i < NI; i++) begin
            m_owner[i] = -1; m_ptr[i] = 0; m_ten[i] = 0; m_last[i] = 0; m_to[i] = 0;
        end
        @(posedge clk);
        #1;

        // reset with all requests up
        drive(1'b1, 4'b1111);
        drive(1'b1, 4'b1111);

        // single requester, then drop to idle
        repeat (4) drive(1'b0, 4'b0100);
        repeat (2) drive(1'b0, 4'b0000);

        // rotation with all requests held; explicit sequence on MAX_HOLD=2
        drive(1'b1, 4'b0000);
        for (int k = 0; k < 20; k++) begin
            drive(1'b0, 4'b1111);
            if (k < 9) begin
                n_tests++;
                if (gnt_a[1] !== rot_exp[k]) begin
                    n_fail++;
                    $display("FAIL rotation step=%0d got gnt=%b required %b", k, gnt_a[1], rot_exp[k]);
                end
            end
        end

        // handoff without bubble
        drive(1'b1, 4'b0000);
        repeat (3) drive(1'b0, 4'b0011);
        repeat (3) drive(1'b0, 4'b0010);
        drive(1'b0, 4'b0000);

        // skip order after a tenure of requester 0
        drive(1'b1, 4'b0000);
        repeat (2) drive(1'b0, 4'b0001);
        drive(1'b0, 4'b0000);
        repeat (3) drive(1'b0, 4'b1001);
        repeat (2) drive(1'b0, 4'b0001);

        // reset mid-tenure
        drive(1'b1, 4'b0000);
        repeat (3) drive(1'b0, 4'b0010);
        drive(1'b1, 4'b0010);
        repeat (3) drive(1'b0, 4'b0110);

        // random traffic with persistent requests and rare resets
        rq = 4'b0000;
        for (int c = 0; c < 2000; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 3) == 0) rq[b] = ~rq[b];
            end
            drive(($urandom_range(0, 99) == 0), rq);
        end

        drive(1'b0, 4'b0000);
        repeat (2) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
